i3c_phy_filt: RTL
=================

Name: i3c_phy_filt

Overview:
Parametrised successor to the single-lane I3C PHY. It sits between the controller FSM and the pad/IO layer. The output path drives SCL and SDA in either open-drain or push-pull mode, selected per line at runtime. The input path adds a configurable-depth synchroniser, a digital glitch filter with runtime bypass, and registered SCL edge and START/STOP detection for the controller.

Parameters:
SyncStages, 2, number of synchroniser flops per input line (≥2).
FilterCycles, 4, consecutive synchronised cycles a new level must hold before it is accepted (≥1). Counter width is $clog2(FilterCycles+1).

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
scl_i  input  1  SCL level from bus
sda_i  input  1  SDA level from bus
scl_o  output  1  SCL drive value to bus
scl_en_o  output  1  SCL output enable
sda_o  output  1  SDA drive value to bus
sda_en_o  output  1  SDA output enable
ctrl_scl_i  input  1  SCL level requested by controller
ctrl_sda_i  input  1  SDA level requested by controller
scl_pp_en_i  input  1  1 = SCL push-pull, 0 = open-drain
sda_pp_en_i  input  1  1 = SDA push-pull, 0 = open-drain
filter_bypass_i  input  1  1 = glitch filter bypassed
ctrl_scl_o  output  1  filtered SCL to controller
ctrl_sda_o  output  1  filtered SDA to controller
scl_posedge_o  output  1  one-cycle pulse on filtered SCL rise
scl_negedge_o  output  1  one-cycle pulse on filtered SCL fall
start_det_o  output  1  one-cycle pulse on START/Sr
stop_det_o  output  1  one-cycle pulse on STOP

Behaviour:
- Single clock clk_i. Reset is asynchronous and active-low on rst_ni. All flops reset asynchronously.
- Reset values:
  - scl_o, sda_o, scl_en_o, sda_en_o = 0 (bus released).
  - Synchroniser flops, filtered and previous-filtered registers = 1, so ctrl_scl_o and ctrl_sda_o = 1.
  - Filter counters = 0; all pulse outputs = 0.
- Output path, registered, 1-cycle latency from ctrl_*_i and *_pp_en_i. Per line:
  - Open-drain: o = 0, en = ~ctrl. Drive low only; high is released to the pull-up.
  - Push-pull: o = ctrl, en = 1.
  - A mode change takes effect on the next edge. No intermediate state is inserted.
- Synchroniser: SyncStages-deep flop chain per line, output sync_x.
- Glitch filter, per line, state = filt_x plus counter cnt_x:
  - bypass = 1: filt_x <= sync_x every cycle; cnt_x <= 0.
  - sync_x == filt_x: cnt_x <= 0.
  - sync_x != filt_x and cnt_x == FilterCycles-1: filt_x <= sync_x, cnt_x <= 0.
  - Otherwise: cnt_x <= cnt_x + 1.
  - A level held for fewer than FilterCycles synchronised cycles is rejected. The counter never exceeds FilterCycles-1.
  - Latency from a pad change to ctrl_x_o = SyncStages + FilterCycles cycles, or SyncStages + 1 when bypassed.
  - Toggling filter_bypass_i mid-count discards the count. It cannot create a spurious edge beyond the one real level change.
- ctrl_scl_o = filt_scl and ctrl_sda_o = filt_sda, both directly from flops.
- Detection uses prev_x <= filt_x registers. Pulses are combinational from flops only and are high exactly one cycle, the first cycle of the new filtered level:
  - scl_posedge_o = ~prev_scl & filt_scl
  - scl_negedge_o = prev_scl & ~filt_scl
  - start_det_o = prev_scl & filt_scl & prev_sda & ~filt_sda
  - stop_det_o = prev_scl & filt_scl & ~prev_sda & filt_sda
- Boundary cases:
  - SCL and SDA changing in the same filtered cycle produce the SCL edge pulse only, never START/STOP.
  - Reset mid-filter clears counts; no pulse fires on reset release because every register resets to 1.

Test Plan:
- Defaults, bypass = 0: scl_i 1→0 held 20 cycles -> ctrl_scl_o falls exactly 6 cycles later; scl_negedge_o high 1 cycle coincident with the fall; no start_det_o or stop_det_o.
- Glitch rejection: 3-cycle low pulse on sda_i with scl_i = 1 -> ctrl_sda_o stays 1, start_det_o never asserts. A 4-cycle pulse -> ctrl_sda_o low for 4 cycles; start_det_o then stop_det_o, one cycle each.
- Bypass: filter_bypass_i = 1 and a 1-cycle scl_i glitch -> ctrl_scl_o shows the glitch 3 cycles later; posedge and negedge pulses 1 cycle apart.
- Drive modes: sda_pp_en_i = 0, ctrl_sda_i = 1 -> sda_en_o = 0, sda_o = 0 next cycle. With ctrl_sda_i = 0 -> sda_en_o = 1, sda_o = 0. Switch to sda_pp_en_i = 1, ctrl_sda_i = 1 -> sda_en_o = 1, sda_o = 1 on the next edge.
- Simultaneous change: scl_i and sda_i fall on the same cycle -> only scl_negedge_o pulses; start_det_o stays 0.
- Reset mid-operation: assert rst_ni low 2 cycles into a filter count -> all outputs return to reset values asynchronously; after release, no pulse output asserts while the pad inputs stay 1.

Source files
------------

// File: rtl/i3c_phy_filt.sv
// rtl/i3c_phy_filt.sv - I3C pad PHY: per-line open-drain/push-pull drive, input synchroniser,
// glitch filter with bypass, and registered SCL edge / START / STOP detection.
module i3c_phy_filt #(
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic scl_en_o,
  output logic sda_o,
  output logic sda_en_o,
  input  logic ctrl_scl_i,
  input  logic ctrl_sda_i,
  input  logic scl_pp_en_i,
  input  logic sda_pp_en_i,
  input  logic filter_bypass_i,
  output logic ctrl_scl_o,
  output logic ctrl_sda_o,
  output logic scl_posedge_o,
  output logic scl_negedge_o,
  output logic start_det_o,
  output logic stop_det_o
);

  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SyncStages-1:0] sync_scl_q;
  logic [SyncStages-1:0] sync_sda_q;
  logic [1:0]            sync_v;
  logic [1:0]            filt_q;
  logic [1:0]            prev_q;
  logic [CntW-1:0]       cnt_q [2];

  // Open-drain only ever pulls low; a released line is left to the pull-up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_o    <= 1'b0;
      scl_en_o <= 1'b0;
      sda_o    <= 1'b0;
      sda_en_o <= 1'b0;
    end else begin
      scl_o    <= scl_pp_en_i ? ctrl_scl_i : 1'b0;
      scl_en_o <= scl_pp_en_i ? 1'b1 : ~ctrl_scl_i;
      sda_o    <= sda_pp_en_i ? ctrl_sda_i : 1'b0;
      sda_en_o <= sda_pp_en_i ? 1'b1 : ~ctrl_sda_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_scl_q <= '1;
      sync_sda_q <= '1;
    end else begin
      sync_scl_q <= {sync_scl_q[SyncStages-2:0], scl_i};
      sync_sda_q <= {sync_sda_q[SyncStages-2:0], sda_i};
    end
  end

  assign sync_v = {sync_sda_q[SyncStages-1], sync_scl_q[SyncStages-1]};

  // Index 0 is SCL, index 1 is SDA. A new level is accepted once it has
  // differed from the filtered level for FilterCycles consecutive cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      cnt_q  <= '{default: '0};
    end else begin
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (filter_bypass_i) begin
          filt_q[i] <= sync_v[i];
          cnt_q[i]  <= '0;
        end else if (sync_v[i] == filt_q[i]) begin
          cnt_q[i]  <= '0;
        end else if (cnt_q[i] == CntLast) begin
          filt_q[i] <= sync_v[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i]  <= cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign ctrl_scl_o = filt_q[0];
  assign ctrl_sda_o = filt_q[1];

  // START/STOP require SCL stable high across both cycles, so an SCL edge
  // coinciding with an SDA edge is reported only as the SCL edge.
  assign scl_posedge_o = ~prev_q[0] &  filt_q[0];
  assign scl_negedge_o =  prev_q[0] & ~filt_q[0];
  assign start_det_o   =  prev_q[0] &  filt_q[0] &  prev_q[1] & ~filt_q[1];
  assign stop_det_o    =  prev_q[0] &  filt_q[0] & ~prev_q[1] &  filt_q[1];

endmodule
